// File: rtl/holo_pkg.sv
// Shared constants and FSM encoding for the POV hologram pipeline
// (column_prefetch_buffer, main, RAM_MMIO).
//   LED_COUNT       pixels per column / strip length
//   TEX_WIDTH       columns per texture
//   NUM_TEXTURES    textures packed side by side in the ROM
//   TOTAL_TEX_WIDTH ROM row stride (all textures of one row)
package holo_pkg;

  localparam int unsigned LED_COUNT       = 52;
  localparam int unsigned TEX_WIDTH       = 128;
  localparam int unsigned NUM_TEXTURES    = 3;
  localparam int unsigned TOTAL_TEX_WIDTH = TEX_WIDTH * NUM_TEXTURES;
  localparam int unsigned THETA_BITS      = 6;
  localparam int unsigned PX_BITS         = 6;
  localparam int unsigned DATA_WIDTH      = 24;
  localparam int unsigned ADDR_WIDTH      = 15;
  localparam int unsigned ROM_LATENCY     = 1;
  localparam int unsigned TEX_SEL_BITS    = 4;

  localparam int unsigned COL_BITS = $clog2(TEX_WIDTH);
  localparam int unsigned TEX_BITS = $clog2(NUM_TEXTURES);
  localparam int unsigned ROW_BITS = $clog2(LED_COUNT + 1);
  localparam int unsigned IDX_BITS = $clog2(LED_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } holo_state_t;

endpackage

// File: rtl/column_bank_pair.sv
// Two LED_COUNT-deep pixel banks. Writes always land in the shadow bank
// (the one not selected by active_sel); the registered read port only ever
// sees the active bank.
//   clk, reset  clock, asynchronous active-low reset (clears both banks)
//   active_sel  bank currently shown on the strip
//   we/waddr/wdata  shadow-bank write port
//   raddr       pixel index; indices >= LED_COUNT read as 0
//   rdata       active-bank pixel, one cycle after raddr
module column_bank_pair
  import holo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_sel,
  input  logic                  we,
  input  logic [IDX_BITS-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PX_BITS-1:0]    raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [PX_BITS-1:0] LAST_PX = PX_BITS'(LED_COUNT - 1);

  logic [DATA_WIDTH-1:0] mem [2][LED_COUNT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < LED_COUNT; i++) begin
          mem[1'(b)][IDX_BITS'(i)] <= '0;
        end
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[~active_sel][waddr] <= wdata;
      end
      rdata <= (raddr <= LAST_PX) ? mem[active_sel][IDX_BITS'(raddr)] : '0;
    end
  end

endmodule

// File: rtl/column_prefetch_buffer.sv
// Double-buffered column cache between the texture ROM and the strip driver.
// A change of angle/texture burst-reads one LED_COUNT-pixel column into the
// shadow bank; banks swap only on a strip frame wrap (px_idx 51 -> 0).
//   clk, reset    clock, asynchronous active-low reset
//   theta         angle index
//   texture_idx   texture select (out-of-range values mean texture 0)
//   rom_addr      texture ROM read address (registered)
//   rom_data      texture ROM data, ROM_LATENCY cycles after rom_addr
//   px_idx        strip pixel index
//   px_data       active-bank pixel, 1-cycle latency
//   busy          fill in progress or waiting for the swap
//   swap_pulse    one cycle, coincident with the bank swap
//   coalesce_cnt  saturating count of input changes seen while busy
module column_prefetch_buffer
  import holo_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [THETA_BITS-1:0]   theta,
  input  logic [TEX_SEL_BITS-1:0] texture_idx,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  input  logic [PX_BITS-1:0]      px_idx,
  output logic [DATA_WIDTH-1:0]   px_data,
  output logic                    busy,
  output logic                    swap_pulse,
  output logic [7:0]              coalesce_cnt
);

  localparam int unsigned          KEY_BITS   = THETA_BITS + TEX_BITS;
  localparam int unsigned          PROD_BITS  = THETA_BITS + COL_BITS;
  localparam logic [ROW_BITS-1:0]  LAST_ROW   = ROW_BITS'(LED_COUNT - 1);
  localparam logic [ROW_BITS-1:0]  ROW_END    = ROW_BITS'(LED_COUNT);
  localparam logic [PX_BITS-1:0]   LAST_PX    = PX_BITS'(LED_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(TOTAL_TEX_WIDTH);

  holo_state_t state;

  logic [TEX_BITS-1:0]   tex;
  logic [PROD_BITS-1:0]  col_prod;
  logic [COL_BITS-1:0]   col;
  logic [ADDR_WIDTH-1:0] base;
  logic [KEY_BITS-1:0]   key;
  logic [KEY_BITS-1:0]   key_q;
  logic [KEY_BITS-1:0]   target_key;
  logic [KEY_BITS-1:0]   loaded_key;
  logic                  loaded_valid;
  logic                  active_bank;
  logic [ROW_BITS-1:0]   row;
  logic                  issue;
  logic [PX_BITS-1:0]    px_idx_q;
  logic                  frame_wrap;

  // Row tags travel alongside the ROM read so each word lands in the row
  // that requested it, whatever the ROM latency.
  logic [ROM_LATENCY-1:0]               tag_vld;
  logic [ROM_LATENCY-1:0][ROW_BITS-1:0] tag_row;
  logic                                 wr_en;
  logic [ROW_BITS-1:0]                  wr_row;

  always_comb begin
    tex        = (texture_idx < TEX_SEL_BITS'(NUM_TEXTURES)) ? TEX_BITS'(texture_idx) : '0;
    col_prod   = PROD_BITS'(theta) * PROD_BITS'(TEX_WIDTH);
    col        = COL_BITS'(col_prod >> THETA_BITS);
    base       = ADDR_WIDTH'(tex) * ADDR_WIDTH'(TEX_WIDTH) + ADDR_WIDTH'(col);
    key        = {theta, tex};
    issue      = (state == ST_FILL) && (row != ROW_END);
    wr_en      = tag_vld[ROM_LATENCY-1];
    wr_row     = tag_row[ROM_LATENCY-1];
    frame_wrap = (px_idx_q == LAST_PX) && (px_idx == '0);
    busy       = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      rom_addr     <= '0;
      row          <= '0;
      tag_vld      <= '0;
      tag_row      <= '0;
      key_q        <= '0;
      target_key   <= '0;
      loaded_key   <= '0;
      loaded_valid <= 1'b0;
      active_bank  <= 1'b0;
      px_idx_q     <= '0;
      swap_pulse   <= 1'b0;
      coalesce_cnt <= '0;
    end else begin
      swap_pulse <= 1'b0;
      px_idx_q   <= px_idx;
      key_q      <= key;
      tag_vld    <= ROM_LATENCY'({tag_vld, issue});
      tag_row    <= (ROM_LATENCY * ROW_BITS)'({tag_row, row});

      if (busy && (key != key_q) && (coalesce_cnt != 8'hFF)) begin
        coalesce_cnt <= coalesce_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (!loaded_valid || (key != loaded_key)) begin
            target_key <= key;
            rom_addr   <= base;
            row        <= '0;
            state      <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Address advances by the row stride instead of base + row*stride;
          // it holds on the last row's address once issuing is done.
          if (issue) begin
            row <= row + 1'b1;
            if (row != LAST_ROW) begin
              rom_addr <= rom_addr + ROW_STRIDE;
            end
          end
          if (wr_en && (wr_row == LAST_ROW)) begin
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (frame_wrap) begin
            active_bank  <= ~active_bank;
            swap_pulse   <= 1'b1;
            loaded_key   <= target_key;
            loaded_valid <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  column_bank_pair u_banks (
    .clk        (clk),
    .reset      (reset),
    .active_sel (active_bank),
    .we         (wr_en),
    .waddr      (IDX_BITS'(wr_row)),
    .wdata      (rom_data),
    .raddr      (px_idx),
    .rdata      (px_data)
  );

endmodule
